onehot_step_decoder: RTL
========================

ONEHOT_STEP_DECODER -- requirements
Module: onehot_step_decoder

Interface
REQ-001 The block SHALL have ports: clock  in  1  sole clock, rising edge active.
REQ-002 reset  in  1  asynchronous, active-high; clears all state.
REQ-003 clear  in  1  synchronous clear of state and counters, active-high.
REQ-004 phase_in  in  4  one-hot ring phase (0001,0010,0100,1000) from the step generator.
REQ-005 step  out  1  single-cycle pulse per accepted phase advance.
REQ-006 dir  out  1  direction of the current step: 1 forward, 0 backward.
REQ-007 wrap  out  1  single-cycle pulse, coincident with step, on ring wrap.
REQ-008 index  out  2  binary index of the last accepted phase (0001->0 ... 1000->3).
REQ-009 step_count  out  8  net step count, modulo 256.
REQ-010 locked  out  1  high in LOCKED state.
REQ-011 fault  out  1  high in FAULT state.
REQ-012 err_count  out  4  number of faults detected, saturating at 15.

Function
REQ-013 phase_in SHALL be sampled every rising clock edge; all outputs SHALL be registered, reflecting the sample taken at edge N from edge N onward (one-cycle latency from phase_in stable to outputs).
REQ-014 A sample is valid only if exactly one bit of phase_in is set; 0000 and multi-bit codes are invalid.
REQ-015 States: UNSYNC, LOCKED, FAULT; reset and clear enter UNSYNC.
REQ-016 UNSYNC: valid sample -> LOCKED, index loaded, no step pulse; invalid sample -> remain UNSYNC, no fault, err_count unchanged.
REQ-017 LOCKED, sample equal to current phase: hold, no pulses.
REQ-018 LOCKED, sample one position forward (0001->0010->0100->1000->0001): step=1, dir=1, index updated, step_count+1 modulo 256 (255 wraps to 0).
REQ-019 LOCKED, forward transition 1000->0001: wrap=1 in the same cycle as step.
REQ-020 LOCKED, invalid sample or two-position jump (e.g. 0001->0100): -> FAULT, no step, index held, err_count+1 saturating at 15.
REQ-021 LOCKED, one position backward: handled per REQ-029/REQ-030.
REQ-022 FAULT: return to LOCKED only after two consecutive identical valid samples; index loaded from that code, no step pulse; invalid samples in FAULT do not increment err_count.
REQ-023 step and wrap SHALL be low in every cycle not producing an accepted step; dir holds its last value between steps.
REQ-024 clear SHALL have priority over any transition in the same cycle.

Reset
REQ-025 On reset assertion, immediately and independent of clock: state UNSYNC, step=0, wrap=0, dir=1, index=0, step_count=0, locked=0, fault=0, err_count=0.
REQ-026 Reset mid-step SHALL abort any pending pulse; no step SHALL be emitted on the first valid sample after reset release.
REQ-027 clear SHALL produce the same values as reset, on the next rising edge.

Configuration
REQ-028 Macro STEP_BACKWARD_EN selects backward-step support.
REQ-029 With STEP_BACKWARD_EN defined: one-position backward transition in LOCKED -> step=1, dir=0, step_count-1 modulo 256 (0 wraps to 255), wrap=1 on 0001->1000.
REQ-030 Without STEP_BACKWARD_EN: backward transition treated as fault per REQ-020; dir tied to 1.

Verification
REQ-031 Reset, then phase_in 0001 held 3 cycles -> locked=1 after first edge, step never asserted, step_count=0, index=0.
REQ-032 Locked at 0001, apply 0010,0100,1000,0001 one per cycle -> four step pulses, wrap=1 only with the 0001 sample, step_count=4, index=0.
REQ-033 Locked at 0010, apply 1000 -> fault=1, locked=0, err_count=1, no step; then 0100 twice -> locked=1, index=2, step_count unchanged.
REQ-034 256 forward steps from step_count=0 -> step_count=0; 16 faults -> err_count stays 15.
REQ-035 Locked at 0001, apply 1000 -> with STEP_BACKWARD_EN: step=1, dir=0, wrap=1, step_count=255; without: fault=1, err_count=1.
REQ-036 Assert reset asynchronously mid-sequence and clear coincident with a forward step -> all outputs at REQ-025 values, no step pulse emitted.

Source files
------------

// File: rtl/onehot_step_decoder.sv
// Decodes a 4-phase one-hot ring into step/direction pulses with lock and fault tracking.
// Backward stepping is enabled by defining STEP_BACKWARD_EN; otherwise a backward move is a fault.
module onehot_step_decoder (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic [3:0] phase_in,
  output logic       step,
  output logic       dir,
  output logic       wrap,
  output logic [1:0] index,
  output logic [7:0] step_count,
  output logic       locked,
  output logic       fault,
  output logic [3:0] err_count
);

  typedef enum logic [1:0] {UNSYNC, LOCKED, FAULT} state_t;

  state_t     state_q, state_d;
  logic       step_d, dir_d, wrap_d;
  logic [1:0] index_d;
  logic [7:0] cnt_d;
  logic [3:0] err_d;
  logic [3:0] cand_q, cand_d;
  logic       cand_vld_q, cand_vld_d;
  logic       valid;
  logic [1:0] enc;
  logic [1:0] delta;
  logic       go_fault;

  always_comb begin
    valid = $onehot(phase_in);
    enc   = 2'd0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (phase_in[i]) enc = i[1:0];
    end
    // ring distance from the last accepted phase; modulo-4 via 2-bit wrap
    delta = enc - index;
  end

  always_comb begin
    state_d    = state_q;
    step_d     = 1'b0;
    wrap_d     = 1'b0;
    dir_d      = dir;
    index_d    = index;
    cnt_d      = step_count;
    err_d      = err_count;
    cand_d     = cand_q;
    cand_vld_d = cand_vld_q;
    go_fault   = 1'b0;

    unique case (state_q)
      UNSYNC: begin
        if (valid) begin
          state_d = LOCKED;
          index_d = enc;
        end
      end
      LOCKED: begin
        if (!valid) begin
          go_fault = 1'b1;
        end else begin
          unique case (delta)
            2'd0: ;
            2'd1: begin
              step_d  = 1'b1;
              dir_d   = 1'b1;
              wrap_d  = (enc == 2'd0);
              index_d = enc;
              cnt_d   = step_count + 8'd1;
            end
            2'd3: begin
`ifdef STEP_BACKWARD_EN
              step_d  = 1'b1;
              dir_d   = 1'b0;
              wrap_d  = (enc == 2'd3);
              index_d = enc;
              cnt_d   = step_count - 8'd1;
`else
              go_fault = 1'b1;
`endif
            end
            default: go_fault = 1'b1;
          endcase
        end
      end
      FAULT: begin
        // relock needs two consecutive identical valid samples seen while in FAULT
        if (valid && cand_vld_q && (phase_in == cand_q)) begin
          state_d    = LOCKED;
          index_d    = enc;
          cand_vld_d = 1'b0;
        end else begin
          cand_d     = phase_in;
          cand_vld_d = valid;
        end
      end
      default: state_d = UNSYNC;
    endcase

    if (go_fault) begin
      state_d    = FAULT;
      cand_vld_d = 1'b0;
      err_d      = (err_count == 4'hF) ? err_count : err_count + 4'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= UNSYNC;
      step       <= 1'b0;
      wrap       <= 1'b0;
      dir        <= 1'b1;
      index      <= '0;
      step_count <= '0;
      err_count  <= '0;
      cand_q     <= '0;
      cand_vld_q <= 1'b0;
    end else if (clear) begin
      state_q    <= UNSYNC;
      step       <= 1'b0;
      wrap       <= 1'b0;
      dir        <= 1'b1;
      index      <= '0;
      step_count <= '0;
      err_count  <= '0;
      cand_q     <= '0;
      cand_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      step       <= step_d;
      wrap       <= wrap_d;
      dir        <= dir_d;
      index      <= index_d;
      step_count <= cnt_d;
      err_count  <= err_d;
      cand_q     <= cand_d;
      cand_vld_q <= cand_vld_d;
    end
  end

  assign locked = (state_q == LOCKED);
  assign fault  = (state_q == FAULT);

endmodule
